pipe_stage_buf: RTL and testbench

//  Parametrised pipeline stage register for inter-stage boundaries (ID/EXE, EXE/MEM, ...).
//  It replaces fixed-field stage registers with a generic CTRL/DATA payload.

---
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic valid/ready pipeline stage register with an optional
// skid entry, flush, bubble injection and a capture-time control kill mask.
module pipe_stage_buf #(
  parameter int                CTRL_W    = 16,
  parameter int                DATA_W    = 192,
  parameter int                DEPTH     = 2,
  parameter logic [CTRL_W-1:0] KILL_MASK = 16'h0001,
  parameter bit                CLR_DATA  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              kill,
  input  logic              bubble_req,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              ready_q;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic              head_bubble;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              head_free;
  logic [CTRL_W-1:0] cap_ctrl;
  logic [DATA_W-1:0] clr_data;

  assign out_valid  = (state != EMPTY);
  assign out_ctrl   = head_ctrl;
  assign out_data   = head_data;
  assign out_bubble = head_bubble;
  assign occupancy  = state;

  // Head slot can be (re)loaded at the next edge: empty now, or being popped.
  assign head_free = ~out_valid | out_ready;

  // ready_q stays low during reset so in_ready rises only after the first edge.
  if (DEPTH == 1) begin : g_plain
    assign in_ready = ready_q & head_free & ~bubble_req;
  end else begin : g_skid
    assign in_ready = ready_q & ~bubble_req;
  end

  assign accept   = in_valid & in_ready & ~flush;
  assign cap_ctrl = in_ctrl & ~(kill ? KILL_MASK : '0);
  assign clr_data = CLR_DATA ? '0 : head_data;

  // Priority: flush, then head reload (skid, input, bubble), then skid capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      ready_q     <= 1'b0;
      head_ctrl   <= '0;
      head_data   <= '0;
      head_bubble <= 1'b0;
      skid_ctrl   <= '0;
      skid_data   <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      ready_q     <= 1'b1;
      head_ctrl   <= '0;
      head_data   <= clr_data;
      head_bubble <= 1'b0;
    end else if (head_free) begin
      ready_q <= 1'b1;
      if (state == FULL) begin
        state       <= ONE;
        head_ctrl   <= skid_ctrl;
        head_data   <= skid_data;
        head_bubble <= 1'b0;
      end else if (accept) begin
        state       <= ONE;
        head_ctrl   <= cap_ctrl;
        head_data   <= in_data;
        head_bubble <= 1'b0;
      end else if (bubble_req) begin
        state       <= ONE;
        head_ctrl   <= '0;
        head_data   <= clr_data;
        head_bubble <= 1'b1;
      end else begin
        state       <= EMPTY;
        head_ctrl   <= '0;
        head_data   <= clr_data;
        head_bubble <= 1'b0;
      end
    end else if (accept) begin
      state     <= FULL;
      ready_q   <= 1'b0;
      skid_ctrl <= cap_ctrl;
      skid_data <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed stimulus with a scoreboard queue; a monitor pops
// expected entries whenever the stage hands one downstream.
module tb_pipe_stage_buf;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 192;
  localparam int W      = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              kill;
  logic              bubble_req;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              out_bubble;
  logic [1:0]        occupancy;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              bubble;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int     tests_run    = 0;
  int     tests_failed = 0;

  pipe_stage_buf #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .DEPTH     (2),
    .KILL_MASK (16'h0001),
    .CLR_DATA  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .kill       (kill),
    .bubble_req (bubble_req),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .out_bubble (out_bubble),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                               input logic k, input logic b, input logic f, input logic r);
    in_valid   = v;
    in_ctrl    = c;
    in_data    = d;
    kill       = k;
    bubble_req = b;
    flush      = f;
    out_ready  = r;
  endtask

  function automatic logic [DATA_W-1:0] mkData(input int k);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ k[31:0];
    return {6{w}};
  endfunction

  function automatic entry_t mkEntry(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic b);
    entry_t e;
    e.ctrl   = c;
    e.data   = d;
    e.bubble = b;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", W'(out_ctrl), W'(0));
        if (out_ctrl == '0) checkOutput("unexpected_output_valid", W'(out_valid), W'(0));
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_ctrl", W'(out_ctrl), W'(mon_e.ctrl));
        checkOutput("sb_data", W'(out_data), W'(mon_e.data));
        checkOutput("sb_bubble", W'(out_bubble), W'(mon_e.bubble));
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_out_ctrl", W'(out_ctrl), W'(0));
    checkOutput("rst_out_data", W'(out_data), W'(0));
    checkOutput("rst_out_bubble", W'(out_bubble), W'(0));
    checkOutput("rst_occupancy", W'(occupancy), W'(0));
    #10 reset = 1'b1;
    step();
    checkOutput("post_rst_in_ready", W'(in_ready), W'(1));

    // Single entry flows through with one cycle latency.
    applyStimulus(1'b1, 16'h00A5, mkData(1), 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mkEntry(16'h00A5, mkData(1), 1'b0));
    step();
    checkOutput("t1_out_valid", W'(out_valid), W'(1));
    checkOutput("t1_out_ctrl", W'(out_ctrl), W'(16'h00A5));
    checkOutput("t1_occupancy", W'(occupancy), W'(1));
    checkOutput("t1_in_ready", W'(in_ready), W'(1));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("t1_drain_occ", W'(occupancy), W'(0));

    // Fill the skid buffer with downstream stalled, then drain in order.
    applyStimulus(1'b1, 16'h0001, mkData(2), 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mkEntry(16'h0001, mkData(2), 1'b0));
    step();
    applyStimulus(1'b1, 16'h0002, mkData(3), 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mkEntry(16'h0002, mkData(3), 1'b0));
    step();
    checkOutput("t2_full_occ", W'(occupancy), W'(2));
    checkOutput("t2_full_in_ready", W'(in_ready), W'(0));
    applyStimulus(1'b1, 16'h0003, mkData(4), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t2_held_occ", W'(occupancy), W'(2));
    checkOutput("t2_stable_ctrl", W'(out_ctrl), W'(16'h0001));
    checkOutput("t2_stable_data", W'(out_data), W'(mkData(2)));
    applyStimulus(1'b1, 16'h0003, mkData(4), 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mkEntry(16'h0003, mkData(4), 1'b0));
    step();
    checkOutput("t2_skid_to_head", W'(out_ctrl), W'(16'h0002));
    checkOutput("t2_one_occ", W'(occupancy), W'(1));
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_last_ctrl", W'(out_ctrl), W'(16'h0003));
    step();
    checkOutput("t2_empty_occ", W'(occupancy), W'(0));

    // Bubble into an empty stage while upstream holds its payload.
    applyStimulus(1'b1, 16'h0042, mkData(5), 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mkEntry('0, '0, 1'b1));
    #1;
    checkOutput("t3_in_ready_blocked", W'(in_ready), W'(0));
    step();
    checkOutput("t3_out_valid", W'(out_valid), W'(1));
    checkOutput("t3_out_bubble", W'(out_bubble), W'(1));
    checkOutput("t3_out_ctrl", W'(out_ctrl), W'(0));
    checkOutput("t3_out_data", W'(out_data), W'(0));
    applyStimulus(1'b1, 16'h0042, mkData(5), 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mkEntry(16'h0042, mkData(5), 1'b0));
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_after_bubble_ctrl", W'(out_ctrl), W'(16'h0042));
    checkOutput("t3_after_bubble_flag", W'(out_bubble), W'(0));
    step();

    // Kill clears the masked control bit on capture.
    applyStimulus(1'b1, 16'hFFFF, mkData(6), 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mkEntry(16'hFFFE, mkData(6), 1'b0));
    step();
    checkOutput("t4_kill_ctrl", W'(out_ctrl), W'(16'hFFFE));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Flush while full discards both held entries and the incoming one.
    applyStimulus(1'b1, 16'h0007, mkData(7), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 16'h0008, mkData(8), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5_full_occ", W'(occupancy), W'(2));
    applyStimulus(1'b1, 16'h0009, mkData(9), 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("t5_flush_occ", W'(occupancy), W'(0));
    checkOutput("t5_flush_valid", W'(out_valid), W'(0));
    checkOutput("t5_flush_in_ready", W'(in_ready), W'(1));
    checkOutput("t5_flush_ctrl", W'(out_ctrl), W'(0));
    checkOutput("t5_flush_data", W'(out_data), W'(0));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("t5_no_ghost", W'(out_valid), W'(0));

    // Pop in the flush cycle still transfers the old head.
    applyStimulus(1'b1, 16'h000A, mkData(10), 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mkEntry(16'h000A, mkData(10), 1'b0));
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5b_flush_pop_occ", W'(occupancy), W'(0));

    // Asynchronous reset mid-cycle while full.
    applyStimulus(1'b1, 16'h000B, mkData(11), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 16'h000C, mkData(12), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t6_full_occ", W'(occupancy), W'(2));
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_valid", W'(out_valid), W'(0));
    checkOutput("t6_async_ctrl", W'(out_ctrl), W'(0));
    checkOutput("t6_async_data", W'(out_data), W'(0));
    checkOutput("t6_async_bubble", W'(out_bubble), W'(0));
    checkOutput("t6_async_occ", W'(occupancy), W'(0));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    step();
    checkOutput("t6_post_in_ready", W'(in_ready), W'(1));
    checkOutput("t6_post_occ", W'(occupancy), W'(0));

    checkOutput("sb_queue_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
